regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Sequencer and arbiter for the single write port of the 32x32 register file. It shares that port between the core writeback path and a debug/host write channel, and provides a soft-clear sweep that zeroes registers 1..31 without a global reset. It sits between the writeback stage and the register file, and drives the file's write-enable, write-address and write-data pins.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NUM_REGS, 32, registers swept by a clear (index 0 never written)
- STARVE_LIMIT, 4, consecutive debug wait cycles before debug preempts core

Ports:
- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk
- reset  in  1  asynchronous active-high reset
- core_we  in  1  core writeback request
- core_waddr  in  ADDR_W  core destination register
- core_wdata  in  DATA_W  core write data
- core_stall  out  1  core write not accepted this cycle; core holds request
- dbg_valid  in  1  debug write request
- dbg_addr  in  ADDR_W  debug destination register
- dbg_wdata  in  DATA_W  debug write data
- dbg_ready  out  1  debug write accepted (transfer = valid & ready)
- clr_start  in  1  single-cycle pulse, begin clear sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse on final sweep write
- rf_we  out  1  to register file RegWrite
- rf_waddr  out  ADDR_W  to register file WriteReg
- rf_wdata  out  DATA_W  to register file WriteData

## Operation
- States: RUN, CLEAR. Reset: state=RUN, ptr=1, wait_cnt=0, clr_done=0, clr_busy=0.
- RUN grant, evaluated every cycle:
  - Core wins if core_we=1 and wait_cnt<STARVE_LIMIT.
  - Debug wins if dbg_valid=1 and (core_we=0 or wait_cnt==STARVE_LIMIT).
  - Debug wins: dbg_ready=1; core_stall=core_we.
  - Core wins: dbg_ready=0; core_stall=0.
- wait_cnt: increments (saturating at STARVE_LIMIT) each cycle dbg_valid=1 and dbg_ready=0. Clears on a debug transfer or when dbg_valid=0.
- Writes to index 0 (either source) complete their handshake / are not stalled, but rf_we=0.
- rf_* are combinational muxes of the granted source. rf_we=0 when nothing is granted.
- clr_start in RUN: the current cycle arbitrates normally; state becomes CLEAR next edge, ptr=1.
- CLEAR:
  - rf_we=1, rf_waddr=ptr, rf_wdata=0.
  - core_stall=core_we, dbg_ready=0, clr_busy=1. wait_cnt frozen.
  - ptr increments each cycle.
  - On ptr==NUM_REGS-1: clr_done=1, then return to RUN with ptr=1.
- clr_start while in CLEAR is ignored (no restart).
- Reset mid-sweep: immediate return to RUN, ptr=1. Partially cleared registers are then cleared by the file's own reset.

## Timing
- Zero-latency grant: a granted request is written on the same clk edge.
- Stalled core request must be held stable until core_stall=0.
- Debug payload must be held stable while dbg_valid=1 and dbg_ready=0.
- Worst-case debug latency with core_we continuously high: STARVE_LIMIT+1 cycles from dbg_valid rising.
- Clear sweep:
  - NUM_REGS-1 cycles (31 by default), starting the cycle after clr_start.
  - clr_busy high for exactly those cycles.
  - clr_done coincides with the write to register NUM_REGS-1.
- Outputs during reset: core_stall=core_we & 0 = 0, dbg_ready per RUN rules, clr_busy=0, clr_done=0.

## Structure
- Package regfile_ctrl_pkg holds:
  - state enum (RUN, CLEAR);
  - DATA_W, ADDR_W, NUM_REGS defaults;
  - REG_ZERO index constant.
- One sub-module, regfile_starve_counter: saturating wait counter with inc/clr/freeze inputs and an at_limit output.
- All other logic stays in the top: state register, ptr, grant mux.

## Test plan
- Core only, core_we=1 to addr 3, data 0xDEAD -> rf_we=1, rf_waddr=3, same cycle, core_stall=0.
- dbg_valid=1 to addr 7 with core_we=0 -> dbg_ready=1 same cycle, rf_wdata=dbg_wdata.
- core_we and dbg_valid both held high -> debug granted on 5th cycle, core_stall=1 that cycle only, wait_cnt back to 0.
- clr_start pulse -> rf_waddr steps 1..31 over 31 cycles with rf_wdata=0, clr_done on addr 31, dbg_ready=0 throughout, second clr_start mid-sweep ignored.
- Core write to addr 0 -> rf_we=0, core_stall=0. Debug write to addr 0 -> dbg_ready=1, rf_we=0.
- Reset asserted at sweep step 10 -> state RUN immediately, clr_busy=0. Next clr_start restarts at addr 1.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and defaults for the register file write arbiter
package regfile_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  // Hard-wired zero register: never written, skipped by the clear sweep.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_starve_counter.sv
// rtl/regfile_starve_counter.sv - saturating count of cycles a debug write has been kept waiting
module regfile_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  input  logic i_freeze,
  output logic o_at_limit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Freeze outranks clear so a clear sweep leaves the waiting history untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_freeze) begin
      r_cnt <= r_cnt;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between core, debug and a clear sweep
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(REG_ZERO + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_clr_done;

  logic w_in_clear;
  logic w_at_limit;
  logic w_core_win;
  logic w_dbg_win;

  assign w_in_clear = (r_state == ST_CLEAR);

  // Debug only overrides a live core request once it has waited the full limit.
  assign w_core_win = !w_in_clear && core_we && !w_at_limit;
  assign w_dbg_win  = !w_in_clear && dbg_valid && (!core_we || w_at_limit);

  assign dbg_ready  = w_dbg_win;
  assign core_stall = core_we && !w_core_win;
  assign clr_busy   = w_in_clear;
  assign clr_done   = r_clr_done;

  regfile_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (dbg_valid && !dbg_ready),
    .i_clr     (!dbg_valid || w_dbg_win),
    .i_freeze  (w_in_clear),
    .o_at_limit(w_at_limit)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_in_clear) begin
      rf_we    = 1'b1;
      rf_waddr = r_ptr;
    end else if (w_dbg_win) begin
      rf_we    = (dbg_addr != ZERO_IDX);
      rf_waddr = dbg_addr;
      rf_wdata = dbg_wdata;
    end else if (w_core_win) begin
      rf_we    = (core_waddr != ZERO_IDX);
      rf_waddr = core_waddr;
      rf_wdata = core_wdata;
    end
  end

  // clr_done is registered one step early so it lands with the write to the last index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_ptr      <= FIRST_IDX;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_clr_done <= 1'b0;
          if (clr_start) begin
            r_state    <= ST_CLEAR;
            r_ptr      <= FIRST_IDX;
            r_clr_done <= (FIRST_IDX == LAST_IDX);
          end
        end
        ST_CLEAR: begin
          if (r_ptr == LAST_IDX) begin
            r_state    <= ST_RUN;
            r_ptr      <= FIRST_IDX;
            r_clr_done <= 1'b0;
          end else begin
            r_ptr      <= r_ptr + 1'b1;
            r_clr_done <= ((r_ptr + 1'b1) == LAST_IDX);
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_ptr      <= FIRST_IDX;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_waddr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_stall;
  logic          dbg_valid = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ready;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          clr_done;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  // Reference: a sweep is "remaining cycles", debug waiting is a plain integer.
  int m_sweep_left = 0;
  int m_wait = 0;
  logic          e_we, e_stall, e_ready, e_busy, e_done;
  int            e_addr;
  logic [DW-1:0] e_data;

  regfile_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata), .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic model_expect();
    bit dbg_gets, core_gets;
    e_we = 0; e_addr = 0; e_data = '0; e_done = 0;
    if (m_sweep_left > 0) begin
      e_addr  = NR - m_sweep_left;
      e_we    = 1;
      e_stall = core_we;
      e_ready = 0;
      e_busy  = 1;
      e_done  = (m_sweep_left == 1);
    end else begin
      dbg_gets  = dbg_valid && (!core_we || m_wait >= SL);
      core_gets = core_we && (m_wait < SL);
      e_ready = dbg_gets;
      e_stall = core_we && !core_gets;
      e_busy  = 0;
      if (dbg_gets) begin
        e_addr = int'(dbg_addr); e_data = dbg_wdata; e_we = (dbg_addr != 0);
      end else if (core_gets) begin
        e_addr = int'(core_waddr); e_data = core_wdata; e_we = (core_waddr != 0);
      end
    end
  endtask

  task automatic model_advance();
    if (m_sweep_left > 0) begin
      m_sweep_left = m_sweep_left - 1;
    end else begin
      model_expect();
      if (dbg_valid && !e_ready) m_wait = (m_wait + 1 > SL) ? SL : m_wait + 1;
      else m_wait = 0;
      if (clr_start) m_sweep_left = NR - 1;
    end
  endtask

  task automatic set_in(input bit cw, input int ca, input logic [DW-1:0] cd,
                        input bit dv, input int da, input logic [DW-1:0] dd, input bit cs);
    core_we = cw; core_waddr = AW'(ca); core_wdata = cd;
    dbg_valid = dv; dbg_addr = AW'(da); dbg_wdata = dd;
    clr_start = cs;
  endtask

  task automatic settle();
    #2;
    model_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_sweep_left = 0; m_wait = 0;
    end else begin
      model_advance();
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1, 4, 32'h1, 0, 0, 0, 0);
    m_sweep_left = 0; m_wait = 0;
    tick(); settle();
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || core_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b stall=%b required 0 0 0", clr_busy, clr_done, core_stall);
    end
    set_in(0, 0, 0, 1, 9, 32'h55, 0);
    settle();
    checks++;
    if (dbg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_dbg_ready got=%b required 1", dbg_ready);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_core_only();
    set_in(1, 3, 32'hDEAD, 0, 0, 0, 0);
    settle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEAD || core_stall !== 1'b0) begin
      failures++;
      $display("FAIL core_only we=%b addr=%0d data=%h stall=%b required 1 3 dead 0",
               rf_we, rf_waddr, rf_wdata, core_stall);
    end
    tick();
  endtask

  task automatic test_dbg_only();
    logic [DW-1:0] d;
    d = $urandom();
    set_in(0, 0, 0, 1, 7, d, 0);
    settle();
    checks++;
    if (dbg_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== d) begin
      failures++;
      $display("FAIL dbg_only ready=%b we=%b addr=%0d data=%h required 1 1 7 %h",
               dbg_ready, rf_we, rf_waddr, rf_wdata, d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 12, 32'hC0C0, 1, 20, 32'hD0D0, 0);
    for (int i = 0; i < SL + 2; i++) begin
      settle();
      checks++;
      if (core_stall !== (i == SL) || dbg_ready !== (i == SL) ||
          rf_waddr !== ((i == SL) ? 5'd20 : 5'd12)) begin
        failures++;
        $display("FAIL starve_cycle%0d stall=%b ready=%b addr=%0d required %b %b %0d", i,
                 core_stall, dbg_ready, rf_waddr, (i == SL), (i == SL), (i == SL) ? 20 : 12);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_clear();
    set_in(0, 0, 0, 0, 0, 0, 1);
    settle();
    checks++;
    if (clr_busy !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL clear_start_cycle busy=%b we=%b required 0 0", clr_busy, rf_we);
    end
    tick();
    for (int i = 1; i < NR; i++) begin
      set_in(1, 6, 32'h6, 1, 5, 32'h5, (i == 10));
      settle();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== AW'(i) || rf_wdata !== '0 || clr_busy !== 1'b1 ||
          dbg_ready !== 1'b0 || core_stall !== 1'b1 || clr_done !== (i == NR - 1)) begin
        failures++;
        $display("FAIL sweep_step%0d we=%b addr=%0d data=%h busy=%b ready=%b stall=%b done=%b",
                 i, rf_we, rf_waddr, rf_wdata, clr_busy, dbg_ready, core_stall, clr_done);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL sweep_end busy=%b done=%b we=%b required 0 0 0", clr_busy, clr_done, rf_we);
    end
    tick();
  endtask

  task automatic test_zero_addr();
    set_in(1, 0, 32'hFFFF, 0, 0, 0, 0);
    settle();
    checks++;
    if (rf_we !== 1'b0 || core_stall !== 1'b0) begin
      failures++;
      $display("FAIL core_zero we=%b stall=%b required 0 0", rf_we, core_stall);
    end
    tick();
    set_in(0, 0, 0, 1, 0, 32'hAAAA, 0);
    settle();
    checks++;
    if (rf_we !== 1'b0 || dbg_ready !== 1'b1) begin
      failures++;
      $display("FAIL dbg_zero we=%b ready=%b required 0 1", rf_we, dbg_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 10; i++) tick();
    settle();
    checks++;
    if (rf_waddr !== 5'd10 || clr_busy !== 1'b1) begin
      failures++;
      $display("FAIL sweep_at_step10 addr=%0d busy=%b required 10 1", rf_waddr, clr_busy);
    end
    reset = 1'b1;
    m_sweep_left = 0; m_wait = 0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || rf_we !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_sweep busy=%b we=%b done=%b required 0 0 0", clr_busy, rf_we, clr_done);
    end
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    checks++;
    if (rf_waddr !== 5'd1 || rf_we !== 1'b1 || clr_busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_sweep addr=%0d we=%b busy=%b required 1 1 1", rf_waddr, rf_we, clr_busy);
    end
    for (int i = 1; i < NR; i++) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(3) != 0), $urandom_range(NR - 1), $urandom(),
             $urandom_range(1), $urandom_range(NR - 1), $urandom(), ($urandom_range(29) == 0));
      settle();
      checks++;
      if (rf_we !== e_we || core_stall !== e_stall || dbg_ready !== e_ready ||
          clr_busy !== e_busy || clr_done !== e_done ||
          (e_we && (rf_waddr !== AW'(e_addr) || rf_wdata !== e_data))) begin
        failures++;
        $display("FAIL random%0d we=%b stall=%b ready=%b busy=%b done=%b addr=%0d data=%h required %b %b %b %b %b %0d %h",
                 n, rf_we, core_stall, dbg_ready, clr_busy, clr_done, rf_waddr, rf_wdata,
                 e_we, e_stall, e_ready, e_busy, e_done, e_addr, e_data);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_dbg_only();
    test_back_to_back();
    test_clear();
    test_zero_addr();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
